// File: rtl/pc_sequencer_if.sv
// Fetch-stage control/status bundle between the front-end control logic and
// the PC sequencer. The master drives the requests, and the slave (the
// sequencer) returns the PC and the status flags.
interface pc_sequencer_if #(
  parameter int N = 32
);
  logic         stall_i;
  logic         branch_i;
  logic [N-1:0] target_i;
  logic         halt_i;
  logic         resume_i;
  logic [N-1:0] pc_o;
  logic [N-1:0] pc_next_o;
  logic         valid_o;
  logic         redirect_o;
  logic         misalign_o;

  modport master (
    output stall_i, branch_i, target_i, halt_i, resume_i,
    input  pc_o, pc_next_o, valid_o, redirect_o, misalign_o
  );

  modport slave (
    input  stall_i, branch_i, target_i, halt_i, resume_i,
    output pc_o, pc_next_o, valid_o, redirect_o, misalign_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// - The registered PC advances by INC each cycle. The sum wraps mod 2^N.
// - Supports stall, branch redirect and halt/resume.
// - BOOT lasts one cycle after reset release, then RUN begins at RESET_VECTOR.
// - Optional feature macro PC_ALIGN_CHECK_EN: when defined, branch targets
//   that are not word aligned are rejected and reported on misalign_o.
//   When undefined, every target is loaded as given.
module pc_sequencer #(
  parameter int           N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = '0,
  parameter int           INC          = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  pc_sequencer_if.slave  bus
);

  localparam logic [N-1:0] INC_N = N'(INC);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t       state;
  logic [N-1:0] pc_q;
  logic         valid_q;
  logic         redirect_q;
  logic         misalign_q;
  logic [N-1:0] pc_inc;
  logic         tgt_ok;

  // Sequential successor of the current PC, truncated to N bits
  assign pc_inc = pc_q + INC_N;

`ifdef PC_ALIGN_CHECK_EN
  assign tgt_ok = (bus.target_i[1:0] == 2'b00);
`else
  assign tgt_ok = 1'b1;
`endif

  // Control FSM: state, PC and all registered status flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= BOOT;
      pc_q       <= RESET_VECTOR;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      misalign_q <= 1'b0;
      case (state)
        BOOT: begin
          state   <= RUN;
          valid_q <= 1'b1;
        end
        RUN: begin
          if (bus.branch_i && tgt_ok) begin
            // An accepted redirect beats halt and stall in the same cycle.
            pc_q       <= bus.target_i;
            redirect_q <= 1'b1;
          end else begin
            // A rejected target falls through to the normal priority chain.
            misalign_q <= bus.branch_i;
            if (bus.halt_i) begin
              state   <= HALT;
              valid_q <= 1'b0;
            end else if (!bus.stall_i) begin
              pc_q <= pc_inc;
            end
          end
        end
        HALT: begin
          // Resume holds the PC, so the first valid fetch is the halted address.
          if (bus.resume_i) begin
            state   <= RUN;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state   <= BOOT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.pc_next_o  = pc_inc;
  assign bus.valid_o    = valid_q;
  assign bus.redirect_o = redirect_q;
  assign bus.misalign_o = misalign_q;

endmodule
